// File: rtl/bsram_arbiter_pkg.sv
// Shared types and sizing helpers for the BSRAM arbiter and its round-robin picker.
package bsram_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Index width for a requester vector; a single requester still needs one bit.
  function automatic int unsigned req_idx_w(input int unsigned num_req);
    int unsigned w;
    w = $clog2(num_req);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bsram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after rr_ptr, with wrap.
module rr_priority_pick
  import bsram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic              found;
  int unsigned       cand;
  logic [IDX_W-1:0]  cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand     = (32'(rr_ptr) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/bsram_arbiter.sv
// Round-robin arbiter sharing one BSRAM among NUM_REQ requesters, with a bounded lock
// mode for read-modify-write and registered 1-cycle responses.
module bsram_arbiter
  import bsram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LOCK_MAX   = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          lock_timeout,
  output logic                          mem_readEnable,
  output logic [ADDR_WIDTH-1:0]         mem_readAddress,
  input  logic [DATA_WIDTH-1:0]         mem_readData,
  output logic                          mem_writeEnable,
  output logic [ADDR_WIDTH-1:0]         mem_writeAddress,
  output logic [DATA_WIDTH-1:0]         mem_writeData
);

  localparam int unsigned IDX_W = req_idx_w(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [CNT_W-1:0]   lock_cnt;

  logic [NUM_REQ-1:0]    pick_grant;
  logic [IDX_W-1:0]      pick_idx;
  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  any_gnt;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    return (32'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
  endfunction

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .idx    (pick_idx)
  );

  // Grant is combinational but gated by reset so nothing reaches the BSRAM while in reset.
  always_comb begin
    gnt     = '0;
    gnt_idx = pick_idx;
    if (reset) begin
      if (state == IDLE) begin
        gnt = pick_grant;
      end else begin
        gnt_idx = owner;
        if (req[owner]) gnt[owner] = 1'b1;
      end
    end
  end

  assign grant     = gnt;
  assign any_gnt   = |gnt;
  assign sel_write = req_write[gnt_idx];
  assign sel_addr  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    mem_readEnable   = 1'b0;
    mem_readAddress  = '0;
    mem_writeEnable  = 1'b0;
    mem_writeAddress = '0;
    mem_writeData    = '0;
    if (any_gnt) begin
      if (sel_write) begin
        mem_writeEnable  = 1'b1;
        mem_writeAddress = sel_addr;
        mem_writeData    = sel_wdata;
      end else begin
        mem_readEnable   = 1'b1;
        mem_readAddress  = sel_addr;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      lock_cnt     <= '0;
      resp_valid   <= '0;
      resp_data    <= '0;
      lock_timeout <= 1'b0;
    end else begin
      resp_valid   <= gnt;
      lock_timeout <= 1'b0;
      if (any_gnt && !sel_write) resp_data <= mem_readData;

      case (state)
        IDLE: begin
          if (any_gnt) begin
            rr_ptr <= next_ptr(pick_idx);
            if (req_lock[pick_idx]) begin
              state    <= LOCKED;
              owner    <= pick_idx;
              lock_cnt <= CNT_W'(1);
            end
          end
        end
        LOCKED: begin
          lock_cnt <= lock_cnt + 1'b1;
          // Dropping req_lock ends the lock whether or not the owner is accessing this cycle;
          // the timeout only fires when the owner would otherwise keep holding.
          if (!req_lock[owner]) begin
            state    <= IDLE;
            rr_ptr   <= next_ptr(owner);
            lock_cnt <= '0;
          end else if (lock_cnt == CNT_W'(LOCK_MAX)) begin
            state        <= IDLE;
            rr_ptr       <= next_ptr(owner);
            lock_cnt     <= '0;
            lock_timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsram_arbiter.sv
// Directed scoreboard bench for bsram_arbiter with two requesters and a behavioural BSRAM.
module tb_bsram_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;

  logic              clock;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR-1:0]     req_write;
  logic [NR-1:0]     req_lock;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     resp_valid;
  logic [DW-1:0]     resp_data;
  logic              lock_timeout;
  logic              mem_readEnable;
  logic [AW-1:0]     mem_readAddress;
  logic [DW-1:0]     mem_readData;
  logic              mem_writeEnable;
  logic [AW-1:0]     mem_writeAddress;
  logic [DW-1:0]     mem_writeData;

  bsram_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LOCK_MAX   (16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req              (req),
    .req_write        (req_write),
    .req_lock         (req_lock),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .grant            (grant),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .lock_timeout     (lock_timeout),
    .mem_readEnable   (mem_readEnable),
    .mem_readAddress  (mem_readAddress),
    .mem_readData     (mem_readData),
    .mem_writeEnable  (mem_writeEnable),
    .mem_writeAddress (mem_writeAddress),
    .mem_writeData    (mem_writeData)
  );

  logic [DW-1:0] sram   [256];
  logic [DW-1:0] shadow [256];

  assign mem_readData = sram[mem_readAddress];
  always @(posedge clock) if (mem_writeEnable) sram[mem_writeAddress] <= mem_writeData;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int unsigned   idx;
    logic          is_read;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] exp_last;
  int unsigned   checks;
  int unsigned   failures;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic r, input logic w, input logic l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]              = r;
    req_write[i]        = w;
    req_lock[i]         = l;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Checks the cycle at its midpoint, then returns just after the next rising edge.
  task automatic tick(input logic [NR-1:0] exp_grant);
    exp_t          e;
    logic [NR-1:0] oh;
    int unsigned   g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clock);
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      oh = '0;
      oh[e.idx] = 1'b1;
      check("resp_valid", 64'(resp_valid), 64'(oh));
      if (e.is_read) exp_last = e.data;
      check("resp_data", 64'(resp_data), 64'(exp_last));
    end else begin
      check("resp_valid_quiet", 64'(resp_valid), 64'(0));
      check("resp_data_hold", 64'(resp_data), 64'(exp_last));
    end
    check("grant", 64'(grant), 64'(exp_grant));
    if (exp_grant == '0) begin
      check("mem_idle", 64'({mem_readEnable, mem_writeEnable, mem_readAddress,
                             mem_writeAddress, mem_writeData}), 64'(0));
    end else begin
      g = exp_grant[1] ? 1 : 0;
      a = req_addr[g*AW +: AW];
      d = req_wdata[g*DW +: DW];
      if (req_write[g]) begin
        check("mem_write", 64'({mem_readEnable, mem_writeEnable, mem_readAddress,
                                mem_writeAddress, mem_writeData}),
              64'({1'b0, 1'b1, 8'h00, a, d}));
        e.is_read = 1'b0;
        e.data    = '0;
        shadow[a] = d;
      end else begin
        check("mem_read", 64'({mem_readEnable, mem_writeEnable, mem_readAddress,
                               mem_writeAddress, mem_writeData}),
              64'({1'b1, 1'b0, a, 8'h00, 32'h0}));
        e.is_read = 1'b1;
        e.data    = shadow[a];
      end
      e.idx = g;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end

  initial begin
    checks    = 0;
    failures  = 0;
    exp_last  = '0;
    reset     = 1'b0;
    req       = '0;
    req_write = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      sram[i]   = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
      shadow[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
    end

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    req = 2'b11;
    #1;
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_data", 64'(resp_data), 64'(0));
    check("rst_lock_timeout", 64'(lock_timeout), 64'(0));
    check("rst_mem", 64'({mem_readEnable, mem_writeEnable, mem_readAddress,
                          mem_writeAddress, mem_writeData}), 64'(0));
    req = '0;
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Alternating reads
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h10, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, 8'h20, '0);
    tick(2'b01);
    tick(2'b10);
    tick(2'b01);
    tick(2'b10);
    req = '0;
    tick(2'b00);

    // Write then read-back from the same requester
    set_req(0, 1'b1, 1'b1, 1'b0, 8'h05, 32'hDEAD_BEEF);
    tick(2'b01);
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h05, '0);
    tick(2'b01);
    req = '0;
    tick(2'b00);
    check("rmw_readback", 64'(resp_data), 64'(32'hDEAD_BEEF));

    // Locked read-modify-write by requester 1 while requester 0 waits
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h40, '0);
    set_req(1, 1'b1, 1'b0, 1'b1, 8'h30, '0);
    tick(2'b10);
    set_req(1, 1'b1, 1'b1, 1'b0, 8'h30, 32'h1234_5678);
    tick(2'b10);
    req[1] = 1'b0;
    tick(2'b01);
    req = '0;
    tick(2'b00);

    // Lock held past LOCK_MAX
    set_req(0, 1'b1, 1'b0, 1'b1, 8'h07, '0);
    tick(2'b01);
    for (int i = 1; i <= 16; i++) begin
      if (i == 2) set_req(1, 1'b1, 1'b0, 1'b0, 8'h21, '0);
      tick(2'b01);
      check("lock_timeout", 64'(lock_timeout), 64'(i == 16));
    end
    req_lock[0] = 1'b0;
    tick(2'b10);
    check("lock_timeout_clear", 64'(lock_timeout), 64'(0));
    req[1] = 1'b0;
    tick(2'b01);
    req = '0;
    tick(2'b00);

    // Reset asserted mid-lock with a read granted
    set_req(0, 1'b1, 1'b0, 1'b1, 8'h08, '0);
    tick(2'b01);
    set_req(0, 1'b1, 1'b0, 1'b1, 8'h09, '0);
    #1;
    check("pre_rst_grant", 64'(grant), 64'(2'b01));
    #1;
    reset = 1'b0;
    #1;
    sb.delete();
    exp_last = '0;
    check("midrst_grant", 64'(grant), 64'(0));
    check("midrst_resp_valid", 64'(resp_valid), 64'(0));
    check("midrst_resp_data", 64'(resp_data), 64'(0));
    check("midrst_mem", 64'({mem_readEnable, mem_writeEnable, mem_readAddress,
                             mem_writeAddress, mem_writeData}), 64'(0));
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h10, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, 8'h20, '0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick(2'b01);
    tick(2'b10);
    req = '0;

    // Idle stretch, then confirm rr_ptr did not move
    for (int i = 0; i < 10; i++) tick(2'b00);
    req = 2'b11;
    tick(2'b01);
    req = '0;
    tick(2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsram_arbiter.md
Name: bsram_arbiter

Overview:
- Shares one BSRAM instance (one read port, one write port, same-cycle read) among NUM_REQ requesters, typically the fetch unit and the memory unit of a core.
- Grants one access per cycle using round-robin arbitration.
- Provides a lock mode so one requester can hold the port across consecutive cycles for read-modify-write sequences.
- Registers the read data and a per-requester response strobe, so every requester sees a fixed 1-cycle response latency.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 32, BSRAM word width.
- ADDR_WIDTH, 8, BSRAM word address width.
- LOCK_MAX, 16, maximum consecutive cycles one owner may hold a lock before forced release (>=2).

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req  in  NUM_REQ  per-requester access request; held until granted.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  request/keep exclusive ownership after this access.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- grant  out  NUM_REQ  one-hot (or zero) combinational grant for this cycle.
- resp_valid  out  NUM_REQ  one-cycle strobe, the cycle after grant.
- resp_data  out  DATA_WIDTH  registered read data, shared by all requesters.
- lock_timeout  out  1  one-cycle pulse when a lock is force-released.
- mem_readEnable  out  1  to BSRAM readEnable.
- mem_readAddress  out  ADDR_WIDTH  to BSRAM readAddress.
- mem_readData  in  DATA_WIDTH  from BSRAM readData, valid in the same cycle.
- mem_writeEnable  out  1  to BSRAM writeEnable.
- mem_writeAddress  out  ADDR_WIDTH  to BSRAM writeAddress.
- mem_writeData  out  DATA_WIDTH  to BSRAM writeData.

Behaviour:
Reset values (reset low):
- State IDLE, rr_ptr=0, owner=0, lock_cnt=0.
- resp_valid=0, resp_data=0, lock_timeout=0.
- grant and all mem_* outputs forced to 0 while reset is low.

IDLE state:
- Grant the first requester with req=1, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
- At most one grant per cycle.
- After any grant to requester g: rr_ptr <= (g+1) mod NUM_REQ.
- If the granted requester has req_lock=1: go to LOCKED, owner <= g, lock_cnt <= 1.

LOCKED state:
- Only owner may be granted; every other req waits, and rr_ptr is frozen.
- A grant to owner with req_lock=0 is the final access; return to IDLE and set rr_ptr <= owner+1.
- If owner has req=0 and req_lock=0: return to IDLE with no grant.
- If owner holds req=0 with req_lock=1: stay LOCKED (idle hold); these cycles still count toward lock_cnt.
- lock_cnt increments every LOCKED cycle.
- When lock_cnt==LOCK_MAX at a clock edge: force IDLE, pulse lock_timeout for 1 cycle, set rr_ptr <= owner+1.
- The owner's access in that same cycle is still granted and completes normally.

Mem drive (combinational from the granted slice):
- Granted read: mem_readEnable=1, mem_readAddress=addr.
- Granted write: mem_writeEnable=1, mem_writeAddress=addr, mem_writeData=wdata.
- The unused mem port and all mem_* signals are 0 when there is no grant.
- Read and write are never issued in the same cycle, so the BSRAM's same-address write bypass is never exercised.

Response:
- Cycle after grant to i: resp_valid[i]=1 and all other bits 0.
- After a read: resp_data <= mem_readData sampled at the grant edge.
- After a write: resp_data holds its previous value; resp_valid still pulses as a write acknowledge.

Requester rules:
- Hold req, req_write, req_addr and req_wdata stable until the cycle in which grant[i]=1.
- A new request may be presented in the cycle after grant.
- Back-to-back accesses by the same requester are allowed, one per cycle.

Reset mid-operation:
- Pending grants are dropped, any lock is released, and no resp_valid is produced for the in-flight access.

Decomposition:
- Shared package: arb_state_t {IDLE, LOCKED}, and the function/constant REQ_IDX_W = clog2(NUM_REQ) (min 1).
- One natural sub-module: rr_priority_pick (combinational). Inputs: req vector and rr_ptr. Outputs: one-hot grant and encoded index. Reusable by other shared units.

Test Plan:
- 2 requesters, both req=1 reads continuously, addr 0x10 and 0x20: grants alternate 0,1,0,1. resp_valid alternates one cycle later. resp_data alternates between sram[0x10] and sram[0x20].
- Req0 writes 0xDEADBEEF to 0x05 at cycle N, then reads 0x05 at N+1: resp_valid[0] at N+1 and N+2. resp_data=0xDEADBEEF at N+2.
- Req1 locks: read 0x30 (lock=1), write 0x30 (lock=0) while req0 holds req=1. Req0 gets no grant for 2 cycles, then is granted in cycle 3.
- Req0 holds req_lock=1 for 20 cycles with LOCK_MAX=16: lock_timeout pulses once after 16 LOCKED cycles. Req1, pending, is granted on the next cycle.
- Assert reset low mid-LOCKED with a read granted: grant, mem_* and resp_valid go 0 immediately. After release, the first grant comes from requester 0 (rr_ptr=0).
- No requests for 10 cycles: all mem_* outputs 0, resp_valid=0, rr_ptr unchanged.
